// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: op encoding,
// FSM states and the RISC-V divide corner-case constants.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } muldiv_state_t;

  localparam int unsigned MAX_XLEN = 64;
  // Quotient on divide-by-zero and remainder on signed overflow.
  localparam logic [MAX_XLEN-1:0] DIVZ_QUOTIENT = '1;
  localparam logic [MAX_XLEN-1:0] OVF_REMAINDER = '0;

  function automatic logic op_is_div(input logic [2:0] o);
    return o[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] o);
    return o[1];
  endfunction

  function automatic logic op_is_unsigned(input logic [2:0] o);
    return o[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Iterative restoring divider on unsigned magnitudes, DIV_STEP quotient bits
// per cycle. Loads on start, iterates XLEN/DIV_STEP cycles.
module muldiv_unit_div_iter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DIV_STEP = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned ITERS = XLEN / DIV_STEP;
  localparam int unsigned CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  logic            run_q, run_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [XLEN:0]   step_r;
  logic [XLEN-1:0] step_q;

  always_comb begin
    step_r = {1'b0, rem_q};
    step_q = quo_q;
    for (int unsigned i = 0; i < DIV_STEP; i++) begin
      step_r = {step_r[XLEN-1:0], step_q[XLEN-1]};
      step_q = {step_q[XLEN-2:0], 1'b0};
      if (step_r >= {1'b0, div_q}) begin
        step_r    = step_r - {1'b0, div_q};
        step_q[0] = 1'b1;
      end
    end
  end

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    div_d = div_q;
    if (abort) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      quo_d = dividend;
      rem_d = '0;
      div_d = divisor;
    end else if (run_q) begin
      quo_d = step_q;
      rem_d = step_r[XLEN-1:0];
      if (cnt_q == LAST) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      div_q <= div_d;
    end
  end

  // High while the final iteration is being computed, so the caller can move
  // to sign fix-up on the same edge the last quotient bits land.
  assign done      = run_q && (cnt_q == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: multi-cycle multiplier, iterative divider,
// sign fix-up and RISC-V divide corner cases, with flush support.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned DIV_STEP    = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enabled,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            completed,
  output logic [XLEN-1:0] result
);

  localparam int unsigned MCW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [MCW-1:0]  MUL_LAST = MCW'(MUL_LATENCY - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q, state_d;
  muldiv_op_t        op_q, op_d;
  logic              busy_q, busy_d;
  logic              completed_q, completed_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [MCW-1:0]    mcnt_q, mcnt_d;
  logic [2*XLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic              quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic              fast_pend_q, fast_pend_d;
  logic [XLEN-1:0]   fast_res_q, fast_res_d;

  logic              accept, div_start, div_done;
  logic              a_neg, b_neg, a_sext, b_sext, div_special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;
  logic [XLEN-1:0]   quo_mag, rem_mag, quo_fix, rem_fix, mul_res;
  logic [2*XLEN-1:0] product;

  assign accept = enabled && !busy_q && !flush;

  always_comb begin
    a_neg  = op_is_div(op) && !op_is_unsigned(op) && rs1[XLEN-1];
    b_neg  = op_is_div(op) && !op_is_unsigned(op) && rs2[XLEN-1];
    a_mag  = a_neg ? -rs1 : rs1;
    b_mag  = b_neg ? -rs2 : rs2;
    a_sext = !op[2] && (op != OP_MULHU) && rs1[XLEN-1];
    b_sext = !op[2] && !op[1] && rs2[XLEN-1];
    div_special = (rs2 == '0) ||
                  (!op_is_unsigned(op) && (rs1 == MOST_NEG) && (rs2 == '1));
    if (rs2 == '0) special_res = op_is_rem(op) ? rs1 : DIVZ_QUOTIENT[XLEN-1:0];
    else           special_res = op_is_rem(op) ? OVF_REMAINDER[XLEN-1:0] : rs1;
  end

  assign product = mul_a_q * mul_b_q;
  assign mul_res = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  assign quo_fix = quo_neg_q ? -quo_mag : quo_mag;
  assign rem_fix = rem_neg_q ? -rem_mag : rem_mag;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    busy_d      = busy_q;
    completed_d = 1'b0;
    result_d    = result_q;
    mcnt_d      = mcnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    fast_pend_d = 1'b0;
    fast_res_d  = fast_res_q;
    div_start   = 1'b0;

    // Fast-path results complete one edge after accept without raising busy,
    // so a following accept on that same edge cannot collide with it.
    if (fast_pend_q) begin
      completed_d = 1'b1;
      result_d    = fast_res_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = muldiv_op_t'(op);
          if (!op_is_div(op)) begin
            state_d = ST_MUL;
            busy_d  = 1'b1;
            mcnt_d  = '0;
            mul_a_d = {{XLEN{a_sext}}, rs1};
            mul_b_d = {{XLEN{b_sext}}, rs2};
          end else if (div_special) begin
            fast_pend_d = 1'b1;
            fast_res_d  = special_res;
          end else begin
            state_d   = ST_DIV;
            busy_d    = 1'b1;
            div_start = 1'b1;
            quo_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
          end
        end
      end
      ST_MUL: begin
        if (mcnt_q == MUL_LAST) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          completed_d = 1'b1;
          result_d    = mul_res;
          mcnt_d      = '0;
        end else begin
          mcnt_d = mcnt_q + 1'b1;
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        completed_d = 1'b1;
        result_d    = op_is_rem(op_q) ? rem_fix : quo_fix;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d     = ST_IDLE;
      busy_d      = 1'b0;
      completed_d = 1'b0;
      result_d    = result_q;
      mcnt_d      = '0;
      fast_pend_d = 1'b0;
      div_start   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      busy_q      <= 1'b0;
      completed_q <= 1'b0;
      result_q    <= '0;
      mcnt_q      <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      fast_pend_q <= 1'b0;
      fast_res_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      busy_q      <= busy_d;
      completed_q <= completed_d;
      result_q    <= result_d;
      mcnt_q      <= mcnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      fast_pend_q <= fast_pend_d;
      fast_res_q  <= fast_res_d;
    end
  end

  muldiv_unit_div_iter #(
    .XLEN     (XLEN),
    .DIV_STEP (DIV_STEP)
  ) u_div_iter (
    .clk       (clk),
    .rstn      (rstn),
    .start     (div_start),
    .abort     (flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (quo_mag),
    .remainder (rem_mag)
  );

  assign busy      = busy_q;
  assign completed = completed_q;
  assign result    = result_q;

endmodule
